// File: rtl/mux4_1_calling.sv
// mux4_1_calling: 4-to-1 selector built from three 2-to-1 stages, plus a registered copy
module mux4_1_calling_mux2 #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? b : a;
endmodule

module mux4_1_calling #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [1:0]       sel_q
);
    logic [WIDTH-1:0] leaf_a;
    logic [WIDTH-1:0] leaf_b;

    mux4_1_calling_mux2 #(.WIDTH(WIDTH)) u_leaf_a (.a(i0), .b(i1), .s(s0), .y(leaf_a));
    mux4_1_calling_mux2 #(.WIDTH(WIDTH)) u_leaf_b (.a(i2), .b(i3), .s(s0), .y(leaf_b));
    mux4_1_calling_mux2 #(.WIDTH(WIDTH)) u_root   (.a(leaf_a), .b(leaf_b), .s(s1), .y(y));

    // capture the selected data and its select when enabled; reset wins over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q   <= '0;
            sel_q <= 2'b00;
        end else if (en) begin
            y_q   <= y;
            sel_q <= {s1, s0};
        end
    end
endmodule

// File: tb/tb_mux4_1_calling.sv
// tb_mux4_1_calling: directed checks of the 4-to-1 selector at WIDTH=1 and WIDTH=8
module tb_mux4_1_calling;
    logic       clk = 1'b0;
    logic       rst, en, s0, s1;
    logic       a0, a1, a2, a3;
    logic       ya, ya_q;
    logic [1:0] sa_q;
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] yb, yb_q;
    logic [1:0] sb_q;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    mux4_1_calling #(.WIDTH(1)) dut_a (
        .clk(clk), .rst(rst), .i0(a0), .i1(a1), .i2(a2), .i3(a3),
        .s0(s0), .s1(s1), .en(en), .y(ya), .y_q(ya_q), .sel_q(sa_q)
    );

    mux4_1_calling #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .i0(b0), .i1(b1), .i2(b2), .i3(b3),
        .s0(s0), .s1(s1), .en(en), .y(yb), .y_q(yb_q), .sel_q(sb_q)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [3:0] v, input logic [1:0] sel);
        {a3, a2, a1, a0} = v;
        {s1, s0} = sel;
        #1;
    endtask

    logic [3:0] walk_v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] iso_v  [4] = '{4'b1100, 4'b1001, 4'b1010, 4'b0101};
    logic [7:0] wide_e [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

    initial begin
        rst = 1'b1; en = 1'b0; s0 = 1'b0; s1 = 1'b0;
        {a3, a2, a1, a0} = 4'b0000;
        b0 = 8'h11; b1 = 8'h22; b2 = 8'h44; b3 = 8'h88;
        edge_wait();
        edge_wait();
        check("reset_yq_w1", {7'b0, ya_q}, 8'h00);
        check("reset_sel_w1", {6'b0, sa_q}, 8'h00);
        check("reset_yq_w8", yb_q, 8'h00);
        check("reset_sel_w8", {6'b0, sb_q}, 8'h00);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            set_a(walk_v[k], 2'(k));
            check($sformatf("walk_%0d", k), {7'b0, ya}, 8'h01);
        end
        for (int k = 0; k < 4; k++) begin
            set_a(iso_v[k], 2'(k));
            check($sformatf("isolate_%0d", k), {7'b0, ya}, 8'h00);
        end

        en = 1'b1;
        set_a(4'b0010, 2'b01);
        edge_wait();
        check("capture_yq", {7'b0, ya_q}, 8'h01);
        check("capture_sel", {6'b0, sa_q}, 8'h01);
        en = 1'b0;
        set_a(4'b0010, 2'b00);
        check("hold_y", {7'b0, ya}, 8'h00);
        edge_wait();
        check("hold_yq", {7'b0, ya_q}, 8'h01);
        check("hold_sel", {6'b0, sa_q}, 8'h01);

        rst = 1'b1; en = 1'b1;
        set_a(4'b0001, 2'b00);
        check("rst_pre_yq", {7'b0, ya_q}, 8'h01);
        check("rst_y_live", {7'b0, ya}, 8'h01);
        edge_wait();
        check("rst_yq", {7'b0, ya_q}, 8'h00);
        check("rst_sel", {6'b0, sa_q}, 8'h00);
        check("rst_y_after", {7'b0, ya}, 8'h01);
        rst = 1'b0;

        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            {s1, s0} = 2'(k);
            #1;
            check($sformatf("wide_y_%0d", k), yb, wide_e[k]);
            edge_wait();
            check($sformatf("wide_yq_%0d", k), yb_q, wide_e[k]);
            check($sformatf("wide_sel_%0d", k), {6'b0, sb_q}, 8'(k));
        end
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
